// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - Zicsr read-modify-write sequencer sharing the CSR file port with trap saves
module csr_access_ctrl #(
   parameter int          XLEN        = 32,
   parameter logic [11:0] MEPC_ADDR   = 12'h341,
   parameter logic [11:0] MCAUSE_ADDR = 12'h342,
   parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [11:0]     req_addr,
   input  logic [XLEN-1:0] req_src,
   input  logic            req_src_is_x0,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_illegal,
   input  logic            trap_valid,
   output logic            trap_ready,
   input  logic [XLEN-1:0] trap_epc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_tval,
   output logic            trap_done,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_we,
   input  logic [XLEN-1:0] csr_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_WAIT, S_WR, S_RESP, S_T_EPC, S_T_CAUSE, S_T_TVAL
   } state_t;

   state_t          state, state_next;

   // Low two funct3 bits select the operation: 01 write, 10 set, 11 clear, 00 illegal.
   // Bit 2 only marks the immediate forms, whose operand arrives already formed in req_src.
   logic [1:0]      op_q;
   logic [11:0]     addr_q;
   logic [XLEN-1:0] src_q;
   logic            write_q;
   logic            illegal_q;
   logic [XLEN-1:0] old_q;
   logic [XLEN-1:0] epc_q, cause_q, tval_q;
   logic [XLEN-1:0] new_val;

   logic            idle, trap_take, req_take;
   logic            req_write_intent, req_illegal;
   logic            unused_funct3_bit;

   assign unused_funct3_bit = req_funct3[2];

   assign idle      = (state == S_IDLE) && !reset;
   assign trap_take = idle && trap_valid;
   assign req_take  = idle && !trap_valid && req_valid;

   assign req_write_intent = (req_funct3[1:0] == 2'b01) || (req_funct3[1] && !req_src_is_x0);
   assign req_illegal      = (req_funct3[1:0] == 2'b00) ||
                             ((req_addr[11:10] == 2'b11) && req_write_intent);

   // Modified value for the write-back, formed from the old value captured in RD_WAIT
   always_comb begin
      new_val = src_q;
      case (op_q)
         2'b10:   new_val = old_q | src_q;
         2'b11:   new_val = old_q & ~src_q;
         default: new_val = src_q;
      endcase
   end

   // State register and latched operands; reset discards any in-flight transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         src_q     <= '0;
         write_q   <= 1'b0;
         illegal_q <= 1'b0;
         old_q     <= '0;
         epc_q     <= '0;
         cause_q   <= '0;
         tval_q    <= '0;
      end else begin
         state <= state_next;
         if (req_take) begin
            op_q      <= req_funct3[1:0];
            addr_q    <= req_addr;
            src_q     <= req_src;
            write_q   <= req_write_intent;
            illegal_q <= req_illegal;
         end
         if (trap_take) begin
            epc_q   <= {trap_epc[XLEN-1:2], 2'b00};
            cause_q <= trap_cause;
            tval_q  <= trap_tval;
         end
         if (state == S_RD_WAIT) begin
            old_q <= csr_rdata;
         end
      end
   end

   // Next-state and port outputs; the file address is presented in the accept cycle so
   // that its registered read data lands in RD_WAIT
   always_comb begin
      state_next   = state;
      req_ready    = 1'b0;
      trap_ready   = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      resp_illegal = 1'b0;
      trap_done    = 1'b0;
      csr_addr     = '0;
      csr_wdata    = '0;
      csr_we       = 1'b0;
      case (state)
         S_IDLE: begin
            trap_ready = idle;
            req_ready  = idle && !trap_valid;
            if (trap_take) begin
               state_next = S_T_EPC;
            end else if (req_take) begin
               if (req_illegal) begin
                  state_next = S_RESP;
               end else begin
                  csr_addr   = req_addr;
                  state_next = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            csr_addr   = addr_q;
            state_next = write_q ? S_WR : S_RESP;
         end
         S_WR: begin
            csr_we     = 1'b1;
            csr_addr   = addr_q;
            csr_wdata  = new_val;
            state_next = S_RESP;
         end
         S_RESP: begin
            resp_valid   = 1'b1;
            resp_illegal = illegal_q;
            resp_rdata   = illegal_q ? '0 : old_q;
            state_next   = S_IDLE;
         end
         S_T_EPC: begin
            csr_we     = 1'b1;
            csr_addr   = MEPC_ADDR;
            csr_wdata  = epc_q;
            state_next = S_T_CAUSE;
         end
         S_T_CAUSE: begin
            csr_we     = 1'b1;
            csr_addr   = MCAUSE_ADDR;
            csr_wdata  = cause_q;
            state_next = S_T_TVAL;
         end
         S_T_TVAL: begin
            csr_we     = 1'b1;
            csr_addr   = MTVAL_ADDR;
            csr_wdata  = tval_q;
            trap_done  = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Sequencer in front of the machine-mode CSR register file. Serialises Zicsr instructions from the execute stage (CSRRW/RS/RC and immediate forms) into read-modify-write transactions on the file's single port. Shares that port with the trap unit, which saves mepc/mcause/mtval. Rejects illegal accesses, including writes to read-only CSRs (addr[11:10]==2'b11, e.g. 0xF10-0xF14).

Parameters:
XLEN, 32, data width of CSRs and operands
MEPC_ADDR, 12'h341, trap save target for epc
MCAUSE_ADDR, 12'h342, trap save target for cause
MTVAL_ADDR, 12'h343, trap save target for tval

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  CSR instruction request from pipeline
req_ready  out  1  request accepted this cycle
req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
req_addr  in  12  CSR address
req_src  in  XLEN  rs1 value or zero-extended uimm, pre-formed
req_src_is_x0  in  1  rs1/uimm field is zero
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  XLEN  old CSR value (to rd)
resp_illegal  out  1  illegal-instruction flag, valid with resp_valid
trap_valid  in  1  trap save request
trap_ready  out  1  trap accepted this cycle
trap_epc  in  XLEN  faulting PC
trap_cause  in  XLEN  mcause value
trap_tval  in  XLEN  mtval value
trap_done  out  1  pulse on last save write
csr_addr  out  12  CSR file address
csr_wdata  out  XLEN  CSR file write data
csr_we  out  1  CSR file write enable
csr_rdata  in  XLEN  CSR file read data, valid one cycle after csr_addr is presented

Behaviour:
- States: IDLE, RD_WAIT, WR, RESP, T_EPC, T_CAUSE, T_TVAL.
- Handshakes:
  - trap_ready = (state==IDLE).
  - req_ready = (state==IDLE) && !trap_valid.
  - Trap wins simultaneous requests. Requests and traps arriving outside IDLE wait; they are never dropped or interrupted.
- IDLE, trap accepted: latch epc/cause/tval, go to T_EPC.
- IDLE, request accepted: latch funct3/addr/src/src_is_x0.
  - write_intent = RW/RWI, or (RS/RC/RSI/RCI and !src_is_x0).
  - Illegal if funct3 is 000 or 100, or if (addr[11:10]==2'b11 && write_intent).
  - Illegal -> RESP with no CSR access. Otherwise present addr and go to RD_WAIT.
- RD_WAIT:
  - csr_addr = latched addr; capture old = csr_rdata.
  - new = src (RW), old|src (RS), old&~src (RC).
  - write_intent -> WR, else RESP.
- WR: csr_we=1, csr_addr=addr, csr_wdata=new -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
  - Illegal: resp_rdata=0, resp_illegal=1.
  - Otherwise: resp_rdata=old, resp_illegal=0.
  - Response has no backpressure.
- T_EPC: we=1, addr=MEPC_ADDR, wdata={epc[XLEN-1:2],2'b00}.
- T_CAUSE: we=1, addr=MCAUSE_ADDR, wdata=cause.
- T_TVAL: we=1, addr=MTVAL_ADDR, wdata=tval, trap_done=1 -> IDLE.
- Latency, with accept cycle = 0:
  - Illegal: resp in cycle 1.
  - Read-only access: resp in cycle 2.
  - Write access: write in cycle 2, resp in cycle 3.
  - Trap: writes in cycles 1-3, trap_done in cycle 3.
- Back-to-back: the next accept is earliest in the cycle after RESP/T_TVAL.
- Outside active states: csr_we=0, csr_addr=0, csr_wdata=0, resp_*=0, trap_done=0.
- Reset (any state): state=IDLE; all outputs 0 from the next edge. Reset mid-operation aborts; no pending write is issued after reset; latched data is discarded.
- Reset values: req_ready=0 and trap_ready=0 while reset is asserted. After reset: req_ready=1, trap_ready=1 (subject to the trap_valid rule above).

Test Plan:
- CSRRW addr 0x300, src 0xDEADBEEF, file holds 0x00001800 -> cycle 2: we=1, addr 0x300, wdata 0xDEADBEEF; cycle 3: resp_valid, rdata 0x00001800, illegal 0.
- CSRRS addr 0xF11, src_is_x0=1, file holds 0 -> no csr_we ever; resp in cycle 2, rdata 0, illegal 0. Same with src=1, src_is_x0=0 -> resp cycle 1, illegal 1, no write.
- CSRRC addr 0x304, old 0x000000FF, src 0x0000000F -> wdata 0x000000F0; resp rdata 0x000000FF.
- trap_valid and req_valid in same IDLE cycle: epc 0x80000006, cause 0x2, tval 0x13 -> trap_ready=1, req_ready=0; writes 0x341=0x80000004, 0x342=0x2, 0x343=0x13 on consecutive cycles; trap_done with the last write; request accepted the next cycle.
- funct3=100 -> resp_illegal=1 in cycle 1, no CSR access.
- Reset asserted during RD_WAIT of a CSRRW -> no csr_we in any later cycle; state IDLE; resp_valid never pulses.
